// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, byte/counter sizes and index-width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam int DMEM_BYTES = 4;
  localparam int CNT_W      = 4;

  // Word-index width for a power-of-two array depth.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled single-port RAM: synchronous write, registered read.
// Ports: clk, i_we/i_re strobes, i_idx word index, i_wdata/i_be, o_rdata.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic                    i_re,
  input  logic [AW-1:0]           i_idx,
  input  logic [31:0]             i_wdata,
  input  logic [DMEM_BYTES-1:0]   i_be,
  output logic [31:0]             o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DMEM_BYTES; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states between request
// accept and response; one transaction outstanding at a time.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_we/
// req_addr/req_wdata/req_be request channel; rsp_valid/rsp_ready/
// rsp_rdata/rsp_err response channel.
// Macro DMEM_ERR_EN: flag out-of-range or misaligned addresses via rsp_err
// instead of aliasing them onto the array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = idx_width(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 =
    (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  dmem_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic             r_rsp_valid;
  logic             r_rd_ok;
  logic             r_err;

  logic             w_idle;
  logic             w_accept;
  logic             w_commit;
  logic             w_we;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;
  logic             w_err;
  logic [31:0]      w_rdata;

  assign w_idle    = (r_state == IDLE);
  assign req_ready = w_idle && !rst;
  assign w_accept  = req_valid && req_ready;

  // With zero latency the access commits on the accept edge itself,
  // so the live request fields are used instead of the latched copy.
  assign w_we    = w_idle ? req_we    : r_we;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_be    = w_idle ? req_be    : r_be;

  always_comb begin
    w_commit = 1'b0;
    if (LATENCY == 0) begin
      w_commit = w_accept;
    end else begin
      w_commit = !rst && (r_state == WAIT) && (r_cnt == '0);
    end
  end

`ifdef DMEM_ERR_EN
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  assign w_err = ({1'b0, w_addr} >= LIMIT) || (w_addr[1:0] != 2'b00);
`else
  logic w_unused;
  assign w_err    = 1'b0;
  assign w_unused = ^{w_addr[31:AW+2], w_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rd_ok     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (LATENCY == 0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_commit) begin
        r_rd_ok <= !w_we && !w_err;
        r_err   <= w_err;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_commit && w_we && !w_err),
    .i_re    (w_commit && !w_we && !w_err),
    .i_idx   (w_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .i_be    (w_be),
    .o_rdata (w_rdata)
  );

  // Array read data is held until the next load commit; stores,
  // errors and reset present zero instead.
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rd_ok ? w_rdata : 32'h0;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances checked
// against a transaction-level memory model, directed and random stimulus.
module tb_dmem_responder;

  localparam int DW = 1024;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0]       req_valid, req_ready, req_we;
  logic [NI-1:0]       rsp_valid, rsp_ready, rsp_err;
  logic [NI-1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [NI-1:0][3:0]  req_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act,
                               input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within cycle budget", nm);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mem [NI][DW];
  logic [3:0]  kn  [NI][DW] = '{default: '0};
  bit          m_busy [NI];
  int          m_cnt  [NI];
  bit          p_we   [NI];
  logic [31:0] p_addr [NI];
  logic [31:0] p_wd   [NI];
  logic [3:0]  p_be   [NI];
  logic [31:0] e_rd   [NI];
  logic [31:0] e_km   [NI];
  bit          e_err  [NI];

  function automatic bit is_err(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return (a >= 32'(DW * 4)) || (a[1:0] != 2'b00);
`else
    return (a != a);
`endif
  endfunction

  function automatic void commit(input int k);
    int w;
    w = int'(p_addr[k][31:2]) % DW;
    e_err[k] = is_err(p_addr[k]);
    e_rd[k]  = '0;
    e_km[k]  = '1;
    if (e_err[k]) return;
    if (p_we[k]) begin
      for (int b = 0; b < 4; b++) begin
        if (p_be[k][b]) begin
          mem[k][w][8*b +: 8] = p_wd[k][8*b +: 8];
          kn[k][w][b] = 1'b1;
        end
      end
    end else begin
      e_rd[k] = mem[k][w];
      for (int b = 0; b < 4; b++) e_km[k][8*b +: 8] = {8{kn[k][w][b]}};
    end
  endfunction

  // Single compare process: checks outputs, then advances the model
  // by the edge that follows.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("req_ready%0d", k), req_ready[k],
           !m_busy[k] && !rst);
      chk1($sformatf("rsp_valid%0d", k), rsp_valid[k],
           m_busy[k] && (m_cnt[k] == 0));
      if (m_busy[k] && m_cnt[k] == 0) begin
        chk($sformatf("rsp_rdata%0d", k), rsp_rdata[k] & e_km[k],
            e_rd[k] & e_km[k]);
        chk1($sformatf("rsp_err%0d", k), rsp_err[k], e_err[k]);
      end
      if (rst) begin
        m_busy[k] = 1'b0;
      end else if (m_busy[k]) begin
        if (m_cnt[k] > 0) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) commit(k);
        end else if (rsp_ready[k]) begin
          m_busy[k] = 1'b0;
        end
      end else if (req_valid[k]) begin
        p_we[k]   = req_we[k];
        p_addr[k] = req_addr[k];
        p_wd[k]   = req_wdata[k];
        p_be[k]   = req_be[k];
        m_busy[k] = 1'b1;
        m_cnt[k]  = lat_of(k);
        if (m_cnt[k] == 0) commit(k);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input int k, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_be[k]    = be;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[k] && n < 50);
    if (!req_ready[k]) timeout("accept");
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_we[k]    = 1'($urandom_range(0, 1));
    req_be[k]    = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[k] && lat < 50);
    rd = rsp_rdata[k];
    er = rsp_err[k];
    if (!rsp_valid[k]) timeout("response");
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, 7)) << 2;
    case ($urandom_range(0, 9))
      0:       return 32'h1000 + w;
      1:       return w + 32'($urandom_range(1, 3));
      default: return w;
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    longint      t0;

    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk1("reset_rsp_valid", rsp_valid[0], 1'b0);
    chk("reset_rsp_rdata", rsp_rdata[0], 32'h0);
    chk1("reset_rsp_err", rsp_err[0], 1'b0);
    chk1("reset_req_ready", req_ready[0], 1'b1);
    @(posedge clk); #1;

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("store_rdata_zero", rd, 32'h0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("lat2_latency", 32'(lat), 32'd3);
    chk("lat2_load", rd, 32'hDEADBEEF);
    chk1("lat2_load_err", er, 1'b0);

    xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    xact(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("lat0_latency", 32'(lat), 32'd1);
    chk("lat0_load", rd, 32'hDEADBEEF);

    xact(0, 1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat);
    xact(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, rd, er, lat);
    chk("be_store_rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("be_load", rd, 32'h00220044);

    rsp_ready[0] = 1'b0;
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("hold_valid", rsp_valid[0], 1'b1);
      chk("hold_rdata", rsp_rdata[0], 32'h00220044);
      chk1("hold_req_ready", req_ready[0], 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("post_hs_req_ready", req_ready[0], 1'b1);
    @(posedge clk); #1;

    t0 = longint'($time);
    for (int i = 0; i < 10; i++) begin
      xact(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    end
    chk("b2b_cycles", 32'((longint'($time) - t0) / 10), 32'd20);

    xact(0, 1'b1, 32'h40, 32'h01020304, 4'hF, rd, er, lat);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h40;
    req_wdata[0] = 32'hCAFEF00D;
    req_be[0]    = 4'hF;
    @(negedge clk);
    chk1("rst_wait_accept", req_ready[0], 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("rst_wait_no_rsp", rsp_valid[0], 1'b0);
    end
    @(posedge clk); #1;
    xact(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("rst_wait_old", rd, 32'h01020304);

    xact(0, 1'b1, 32'h24, 32'h55667788, 4'hF, rd, er, lat);
    xact(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("be0_rsp_rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
    chk("be0_unchanged", rd, 32'h55667788);

    xact(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    xact(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
`ifdef DMEM_ERR_EN
    chk1("oob_store_err", er, 1'b1);
    chk("oob_store_rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
    chk1("misalign_err", er, 1'b1);
    chk("misalign_rdata", rd, 32'h0);
    chk("misalign_latency", 32'(lat), 32'd3);
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    chk("word0_kept", rd, 32'hA5A5A5A5);
    chk1("word0_err", er, 1'b0);
`else
    chk1("alias_store_err", er, 1'b0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    chk("alias_word0", rd, 32'h12345678);
`endif

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) begin
        req_valid[k] = ($urandom_range(0, 2) != 0);
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = rand_addr();
        req_wdata[k] = $urandom;
        req_be[k]    = 4'($urandom);
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
